mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative 32-bit multiply/divide unit for MULT/MULTU/DIV/DIVU, with HI/LO result registers.
//  Sits downstream of reg_file and consumes readData1/readData2 as srcA/srcB.
//  HI/LO are read back through MFHI/MFLO, whose data goes to the reg_file writeData port.
//  One op in flight; busy stalls the issue stage.
// PARAMETERS
//  WIDTH  32  operand/result width; only 32 is supported and verified
// PORTS
//  clk    in   1      clock; all state updates on posedge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      launch op; sampled only in IDLE
//  op     in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  srcA   in   32     multiplicand/dividend (rs)
//  srcB   in   32     multiplier/divisor (rt)
//  mthi   in   1      write srcA into HI (MTHI)
//  mtlo   in   1      write srcA into LO (MTLO)
//  busy   out  1      high while an op is in CALC or FIX
//  done   out  1      one-cycle pulse: HI/LO hold a new result
//  hi     out  32     HI register (product[63:32] / remainder)
//  lo     out  32     LO register (product[31:0] / quotient)
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, busy=0, done=0, counter=0. Takes effect on any edge with rst=1.
//   This includes mid-operation, where the op is aborted and no result is written.
//  States: IDLE -> CALC -> FIX -> IDLE.
//  IDLE:
//   - If start=1 at edge N: latch op, the operand signs and |srcA|, |srcB|.
//   - Signed ops (01, 11) take two's-complement magnitudes. The magnitude of 0x80000000 is 2^31.
//   - Unsigned ops take the raw values.
//   - At the same edge: counter=0, go to CALC, busy=1.
//  CALC: one radix-2 step per edge; counter 0..31.
//   - Multiply: shift-add on a 64-bit accumulator.
//   - Divide: restoring, one quotient bit per edge, with a 33-bit partial remainder.
//   - The edge with counter=31 goes to FIX (edges N+1..N+32).
//  FIX (edge N+33): apply signs, write hi/lo, done=1 for one cycle, busy=0, go to IDLE.
//   - MULT: negate the 64-bit product if signA^signB.
//   - DIV: negate the quotient if signA^signB; negate the remainder if signA (remainder sign = dividend).
//   - Result is visible in the cycle after edge N+33, i.e. 33 cycles after the start edge.
//   - A new start is accepted on that same cycle's edge.
//  done is registered, high exactly one cycle per completed op, and never asserted after reset.
//  Divide by zero, all div ops, defined result: lo=32'hFFFFFFFF, hi=srcA (raw value as issued).
//  Signed overflow 0x80000000 / 0xFFFFFFFF: lo=32'h80000000, hi=0.
//  start while busy: ignored, no queuing.
//  mthi/mtlo while busy: ignored.
//  mthi/mtlo in IDLE without start: written at that edge; the other register is unchanged.
//  mthi=mtlo=1 in IDLE: both registers take srcA.
//  start together with mthi/mtlo in IDLE: start wins and the move is ignored.
//  Operand inputs need only be valid on the start edge. Internal copies are used afterwards,
//   so reg_file may change readData freely while busy.
//  hi/lo hold their values between ops. They change only at FIX, on an accepted mthi/mtlo, or on rst.
// TESTING
//  T1 MULTU A=FFFFFFFF B=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//     done exactly 33 cycles after the start edge; busy high for 33 cycles.
//  T2 MULT A=FFFFFFFD(-3) B=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB(-21).
//     MULT 80000000*80000000 -> hi=40000000, lo=0.
//  T3 DIV A=FFFFFFF9(-7) B=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//     DIVU 64/7 -> lo=9, hi=1.
//  T4 DIVU A=00000064 B=0 -> lo=FFFFFFFF, hi=00000064.
//     DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  T5 start MULTU 2*3, then pulse start (DIVU) and mthi(A=DEAD) at cycle 5 -> both ignored;
//     result hi=0, lo=6. Repeat with rst at cycle 10 -> hi=lo=0, busy=0, no done;
//     next start runs normally.
//  T6 IDLE: mtlo A=12345678 -> lo=12345678 next cycle, hi unchanged.
//     mthi+start together -> move dropped, op result written.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO result
// registers. One radix-2 step per cycle; signs are stripped on issue and
// re-applied in a final fix-up cycle.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } stateType;

   stateType state, nextState;

   logic [1:0]         opReg;
   logic               signA, signB;
   logic [WIDTH-1:0]   magA, magB;
   logic [WIDTH-1:0]   rawA;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;
   logic [CNT_W-1:0]   counter;
   logic [WIDTH-1:0]   hiReg, loReg;
   logic               doneReg;

   logic               isSigned, isDiv, inSigned;
   logic [WIDTH-1:0]   absA, absB;
   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] mulNextAcc;
   logic [WIDTH:0]     divShift;
   logic [WIDTH+1:0]   divDiff;
   logic [WIDTH-1:0]   divNextRem;
   logic [2*WIDTH-1:0] divNextAcc;
   logic [2*WIDTH-1:0] mulRes;
   logic [WIDTH-1:0]   quotRes, remRes;
   logic [WIDTH-1:0]   fixHi, fixLo;

   // Operand magnitudes at issue time (raw values for unsigned ops)
   always_comb begin
      inSigned = op[0];
      absA     = (inSigned && srcA[WIDTH-1]) ? -srcA : srcA;
      absB     = (inSigned && srcB[WIDTH-1]) ? -srcB : srcB;
   end

   // One shift-add multiply step and one restoring divide step
   always_comb begin
      isSigned   = opReg[0];
      isDiv      = opReg[1];
      // multiplier sits in acc[WIDTH-1:0] and shifts out as the product shifts in
      mulSum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magA} : '0);
      mulNextAcc = {mulSum, acc[WIDTH-1:1]};
      // dividend shifts out of acc[WIDTH-1] while quotient bits shift in at bit 0
      divShift   = {rem, acc[WIDTH-1]};
      divDiff    = {1'b0, divShift} - {2'b00, magB};
      divNextRem = divDiff[WIDTH+1] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
      divNextAcc = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~divDiff[WIDTH+1]};
   end

   // Sign fix-up and special-case selection for the final write to HI/LO
   always_comb begin
      mulRes  = (isSigned && (signA ^ signB)) ? -acc : acc;
      quotRes = (isSigned && (signA ^ signB)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      remRes  = (isSigned && signA) ? -rem : rem;
      fixHi   = mulRes[2*WIDTH-1:WIDTH];
      fixLo   = mulRes[WIDTH-1:0];
      if (isDiv) begin
         if (magB == '0) begin
            fixHi = rawA;
            fixLo = '1;
         end else begin
            // 0x80000000 / -1 falls out naturally: |q| = 2^31 negates to itself
            fixHi = remRes;
            fixLo = quotRes;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic and busy flag
   always_comb begin
      nextState = state;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (counter == CNT_W'(WIDTH - 1)) begin
               nextState = FIX;
            end
         end
         FIX: begin
            busy      = 1'b1;
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Datapath: operand latch, iteration, result write and HI/LO moves
   always_ff @(posedge clk) begin
      if (rst) begin
         opReg   <= '0;
         signA   <= 1'b0;
         signB   <= 1'b0;
         magA    <= '0;
         magB    <= '0;
         rawA    <= '0;
         acc     <= '0;
         rem     <= '0;
         counter <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         doneReg <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opReg   <= op;
                  signA   <= inSigned & srcA[WIDTH-1];
                  signB   <= inSigned & srcB[WIDTH-1];
                  magA    <= absA;
                  magB    <= absB;
                  rawA    <= srcA;
                  acc     <= op[1] ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
                  rem     <= '0;
                  counter <= '0;
               end else begin
                  if (mthi) begin
                     hiReg <= srcA;
                  end
                  if (mtlo) begin
                     loReg <= srcA;
                  end
               end
            end
            CALC: begin
               counter <= counter + 1'b1;
               if (isDiv) begin
                  acc <= divNextAcc;
                  rem <= divNextRem;
               end else begin
                  acc <= mulNextAcc;
               end
            end
            FIX: begin
               hiReg   <= fixHi;
               loReg   <= fixLo;
               doneReg <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign hi   = hiReg;
   assign lo   = loReg;
   assign done = doneReg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected HI/LO pushed on issue, popped on done.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] srcA, srcB;
   logic        busy, done;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } expT;

   expT sb[$];
   int  passed = 0;
   int  total = 0;
   int  cyc = 0;
   int  startCyc = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .op   (op),
      .srcA (srcA),
      .srcB (srcB),
      .mthi (mthi),
      .mtlo (mtlo),
      .busy (busy),
      .done (done),
      .hi   (hi),
      .lo   (lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic expT model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      expT r;
      logic signed [63:0] sp;
      logic signed [31:0] sa, sd;
      case (o)
         2'd0: {r.hi, r.lo} = {32'b0, a} * {32'b0, b};
         2'd1: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            {r.hi, r.lo} = sp;
         end
         2'd2: begin
            if (b == 32'd0) begin r.lo = 32'hFFFFFFFF; r.hi = a; end
            else begin r.lo = a / b; r.hi = a % b; end
         end
         default: begin
            if (b == 32'd0) begin r.lo = 32'hFFFFFFFF; r.hi = a; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r.lo = 32'h80000000; r.hi = 32'd0; end
            else begin sa = a; sd = b; r.lo = sa / sd; r.hi = sa % sd; end
         end
      endcase
      return r;
   endfunction

   // Drive one start cycle; returns at the negedge after the start edge.
   task automatic startOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input expT e, input logic mv);
      @(negedge clk);
      start = 1'b1; op = o; srcA = a; srcB = b; mthi = mv;
      startCyc = cyc + 1;
      if (push) sb.push_back(e);
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      srcA = $urandom; srcB = $urandom; op = 2'($urandom_range(0, 3));
      check("busy_after_start", busy, 1);
   endtask

   // Wait (bounded) for done, then check timing and pop the scoreboard.
   task automatic waitDone(input string tag, input int expBusy);
      int  busyCnt = 0;
      bit  seen = 0;
      expT e;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
         else if (busy) busyCnt++;
      end
      check({tag, "_done_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_latency"}, cyc - startCyc, 33);
         check({tag, "_busy_low_at_done"}, busy, 0);
         check({tag, "_busy_cycles"}, busyCnt, expBusy);
         check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_hi"}, hi, e.hi);
            check({tag, "_lo"}, lo, e.lo);
         end
      end
   endtask

   task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input expT e);
      startOp(o, a, b, 1'b1, e, 1'b0);
      waitDone(tag, 32);
   endtask

   initial begin
      int  doneCnt;
      int  busyCnt;
      expT none;
      logic [31:0] ra, rb;
      none = '{32'd0, 32'd0};
      rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = 2'd0; srcA = 32'd0; srcB = 32'd0;

      // Reset dominates start and moves
      @(negedge clk);
      start = 1'b1; mthi = 1'b1; srcA = 32'd5; srcB = 32'd5;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      start = 1'b0; mthi = 1'b0; rst = 1'b0;

      // T1
      runOp("t1_multu", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'hFFFFFFFE, 32'h00000001});
      @(negedge clk);
      check("t1_done_one_cycle", done, 0);

      // T2
      runOp("t2_mult_neg", 2'd1, 32'hFFFFFFFD, 32'h00000007, '{32'hFFFFFFFF, 32'hFFFFFFEB});
      runOp("t2_mult_min", 2'd1, 32'h80000000, 32'h80000000, '{32'h40000000, 32'h00000000});

      // T3
      runOp("t3_div_neg", 2'd3, 32'hFFFFFFF9, 32'h00000002, '{32'hFFFFFFFF, 32'hFFFFFFFD});
      runOp("t3_divu", 2'd2, 32'd64, 32'd7, '{32'd1, 32'd9});

      // T4
      runOp("t4_divu_zero", 2'd2, 32'h00000064, 32'd0, '{32'h00000064, 32'hFFFFFFFF});
      runOp("t4_div_zero", 2'd3, 32'hFFFFFFF0, 32'd0, '{32'hFFFFFFF0, 32'hFFFFFFFF});
      runOp("t4_div_ovf", 2'd3, 32'h80000000, 32'hFFFFFFFF, '{32'h00000000, 32'h80000000});

      // Model-checked operands across all four ops
      for (int k = 0; k < 8; k++) begin
         ra = $urandom;
         rb = (k >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (k == 7) rb = -rb;
         runOp("rand", 2'(k % 4), ra, rb, model(2'(k % 4), ra, rb));
      end

      // T5: start and mthi while busy are ignored
      @(negedge clk); mthi = 1'b1; srcA = 32'h11111111;
      @(negedge clk); mthi = 1'b0;
      check("t5_mthi_prep", hi, 32'h11111111);
      startOp(2'd0, 32'd2, 32'd3, 1'b1, '{32'd0, 32'd6}, 1'b0);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 2'd2; mthi = 1'b1; srcA = 32'h0000DEAD; srcB = 32'd1;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      check("t5_hi_hold_busy", hi, 32'h11111111);
      waitDone("t5_ignored", 27);
      @(negedge clk);
      check("t5_no_second_busy", busy, 0);
      check("t5_no_second_done", done, 0);

      // T5: reset mid-operation aborts without a result
      startOp(2'd0, 32'd2, 32'd3, 1'b0, none, 1'b0);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_rst_hi", hi, 0);
      check("t5_rst_lo", lo, 0);
      check("t5_rst_busy", busy, 0);
      doneCnt = 0; busyCnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) doneCnt++;
         if (busy) busyCnt++;
      end
      check("t5_rst_no_done", doneCnt, 0);
      check("t5_rst_stay_idle", busyCnt, 0);
      runOp("t5_after_rst", 2'd0, 32'd5, 32'd7, '{32'd0, 32'd35});

      // T6: moves in IDLE
      @(negedge clk); mthi = 1'b1; srcA = 32'hAAAA0000;
      @(negedge clk); mthi = 1'b0;
      check("t6_mthi", hi, 32'hAAAA0000);
      check("t6_mthi_lo_kept", lo, 32'd35);
      mtlo = 1'b1; srcA = 32'h12345678;
      @(negedge clk); mtlo = 1'b0;
      check("t6_mtlo", lo, 32'h12345678);
      check("t6_mtlo_hi_kept", hi, 32'hAAAA0000);
      mthi = 1'b1; mtlo = 1'b1; srcA = 32'hCAFEF00D;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
      check("t6_both_hi", hi, 32'hCAFEF00D);
      check("t6_both_lo", lo, 32'hCAFEF00D);
      startOp(2'd0, 32'd4, 32'd5, 1'b1, '{32'd0, 32'd20}, 1'b1);
      check("t6_move_dropped", hi, 32'hCAFEF00D);
      waitDone("t6_start_wins", 32);

      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
